// File: rtl/uart_loader_pkg.sv
// Shared definitions for the serial boot loader: FSM state encoding and frame constants.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [7:0] MAGIC_BYTE      = 8'hA5;
  localparam int         FRAME_HDR_BYTES = 3;

  // A frame is in progress anywhere between the MAGIC byte and the checksum byte
  function automatic logic state_is_busy(loader_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Byte-intake handshake from buart and RAM write port, bundled for the boot loader.
interface uart_loader_if #(
  parameter int ADDR_W = 16
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_rd;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [15:0]       mem_write_data;

  modport master (
    output rx_valid, rx_data,
    input  rx_rd, mem_write_enable, mem_write_addr, mem_write_data
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_rd, mem_write_enable, mem_write_addr, mem_write_data
  );

endinterface

// File: rtl/uart_loader_byte_intake.sv
// rx_valid/rx_rd handshake: registers one byte per acknowledge and hands it on as a one-cycle strobe.
// With LOADER_ECHO_EN each consumed byte is echoed on tx_wr/tx_data and intake stalls while tx_busy.
module loader_byte_intake (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
`ifdef LOADER_ECHO_EN
  input  logic       i_tx_busy,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_data,
`endif
  output logic       o_rx_rd,
  output logic       o_byte_strobe,
  output logic [7:0] o_byte
);

  logic       r_rx_rd;
  logic [7:0] r_byte;
  logic       w_take;

  // The cycle spent acknowledging blocks a second take, so buart has time to drop rx_valid
`ifdef LOADER_ECHO_EN
  assign w_take = i_rx_valid && !r_rx_rd && !i_tx_busy;
`else
  assign w_take = i_rx_valid && !r_rx_rd;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_rd <= 1'b0;
      r_byte  <= 8'h00;
    end else begin
      r_rx_rd <= w_take;
      if (w_take) begin
        r_byte <= i_rx_data;
      end
    end
  end

  assign o_rx_rd       = r_rx_rd;
  assign o_byte_strobe = r_rx_rd;
  assign o_byte        = r_byte;

`ifdef LOADER_ECHO_EN
  assign o_tx_wr   = r_rx_rd;
  assign o_tx_data = r_byte;
`endif

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader: parses MAGIC/LEN/data/CSUM frames into 16-bit RAM writes and releases the CPU
// only after a checksum-verified image. Optional byte echo is enabled by the macro LOADER_ECHO_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC     = MAGIC_BYTE,
  parameter int         MAX_WORDS = 4096,
  parameter int         ADDR_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  uart_loader_if.slave bus,
`ifdef LOADER_ECHO_EN
  input  logic        i_tx_busy,
  output logic        o_tx_wr,
  output logic [7:0]  o_tx_data,
`endif
  output logic        o_cpu_run,
  output logic        o_busy,
  output logic        o_error
);

  loader_state_e     r_state;
  loader_state_e     w_state_next;

  logic              w_strobe;
  logic [7:0]        w_byte;
  logic              w_rx_rd;

  logic [7:0]        r_len_hi;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_index;
  logic [7:0]        r_csum;
  logic [7:0]        r_hi;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;

  logic [ADDR_W-1:0] w_len;
  logic [ADDR_W-1:0] w_index_inc;
  logic              w_last;
  logic              w_len_too_big;

  loader_byte_intake u_intake (
    .clk          (clk),
    .reset        (reset),
    .i_rx_valid   (bus.rx_valid),
    .i_rx_data    (bus.rx_data),
`ifdef LOADER_ECHO_EN
    .i_tx_busy    (i_tx_busy),
    .o_tx_wr      (o_tx_wr),
    .o_tx_data    (o_tx_data),
`endif
    .o_rx_rd      (w_rx_rd),
    .o_byte_strobe(w_strobe),
    .o_byte       (w_byte)
  );

  assign w_len         = ADDR_W'({r_len_hi, w_byte});
  assign w_index_inc   = r_index + ADDR_W'(1);
  assign w_last        = (w_index_inc == r_len);
  assign w_len_too_big = 32'(w_len) > MAX_WORDS;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Every state consumes a byte, so the FSM only moves on a strobe
  always_comb begin
    w_state_next = r_state;
    if (w_strobe) begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_byte == MAGIC) begin
            w_state_next = ST_LEN_HI;
          end
        end
        ST_LEN_HI: w_state_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if (w_len_too_big) begin
            w_state_next = ST_ERROR;
          end else if (w_len == '0) begin
            w_state_next = ST_CHECK;
          end else begin
            w_state_next = ST_DATA_HI;
          end
        end
        ST_DATA_HI: w_state_next = ST_DATA_LO;
        ST_DATA_LO: w_state_next = w_last ? ST_CHECK : ST_DATA_HI;
        ST_CHECK:   w_state_next = (w_byte == r_csum) ? ST_DONE : ST_ERROR;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // Write strobe is registered, so it lands the cycle after the low byte is latched
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_hi <= 8'h00;
      r_len    <= '0;
      r_index  <= '0;
      r_csum   <= 8'h00;
      r_hi     <= 8'h00;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= 16'h0000;
    end else begin
      r_we <= 1'b0;
      if (w_strobe) begin
        case (r_state)
          ST_LEN_HI: r_len_hi <= w_byte;
          ST_LEN_LO: begin
            r_len   <= w_len;
            r_index <= '0;
            r_csum  <= 8'h00;
          end
          ST_DATA_HI: begin
            r_hi   <= w_byte;
            r_csum <= r_csum ^ w_byte;
          end
          ST_DATA_LO: begin
            r_we    <= 1'b1;
            r_addr  <= r_index;
            r_data  <= {r_hi, w_byte};
            r_csum  <= r_csum ^ w_byte;
            r_index <= w_index_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_rd            = w_rx_rd;
  assign bus.mem_write_enable = r_we;
  assign bus.mem_write_addr   = r_addr;
  assign bus.mem_write_data   = r_data;

  assign o_cpu_run = (r_state == ST_DONE);
  assign o_error   = (r_state == ST_ERROR);
  assign o_busy    = state_is_busy(r_state);

endmodule
